// File: rtl/rv_mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package rv_mdu_pkg;

    localparam int MDU_OP_W     = 3;
    localparam int MDU_ITER_NUM = 32;

    localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'b000;
    localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'b001;
    localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'b010;
    localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'b011;
    localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'b100;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'b101;
    localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'b110;
    localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'b111;

    localparam logic [31:0] MDU_DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic mdu_is_mul(input logic [MDU_OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic mdu_is_rem(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic mdu_signed_a(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic mdu_signed_b(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/rv_mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per step; outputs are the
// values after the current step so the caller can capture the final result.
module rv_mdu_div_core
    import rv_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ITER_NUM = MDU_ITER_NUM
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            last_o
);

    localparam int CNT_W = $clog2(ITER_NUM);

    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dsor_q, dsor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    shift_s;
    logic [XLEN-1:0]  diff_s, rem_nxt_s, quo_nxt_s;
    logic             ge_s;

    // One restoring step; the difference fits in XLEN bits whenever it is kept.
    always_comb begin
        shift_s   = {rem_q, quo_q[XLEN-1]};
        diff_s    = shift_s[XLEN-1:0] - dsor_q;
        ge_s      = (shift_s >= {1'b0, dsor_q});
        quo_nxt_s = {quo_q[XLEN-2:0], ge_s};
        if (ge_s) begin
            rem_nxt_s = diff_s;
        end else begin
            rem_nxt_s = shift_s[XLEN-1:0];
        end
    end

    // Load on start, advance on step, otherwise hold.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsor_d = dsor_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = {XLEN{1'b0}};
            dsor_d = divisor_i;
            cnt_d  = {CNT_W{1'b0}};
        end else if (step_i) begin
            quo_d  = quo_nxt_s;
            rem_d  = rem_nxt_s;
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            quo_q  <= {XLEN{1'b0}};
            rem_q  <= {XLEN{1'b0}};
            dsor_q <= {XLEN{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsor_q <= dsor_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quotient_o  = quo_nxt_s;
    assign remainder_o = rem_nxt_s;
    assign last_o      = step_i && (cnt_q == CNT_W'(ITER_NUM - 1));

endmodule

// File: rtl/rv_mdu.sv
// RV32M multiply/divide unit with a multi-cycle FSM and registered result.
// Define RV_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ITER_NUM = MDU_ITER_NUM
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                mdu_req_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]     mdu_port_a_i,
    input  logic [XLEN-1:0]     mdu_port_b_i,
    input  logic                mdu_kill_i,
    output logic [XLEN-1:0]     mdu_result_o,
    output logic                mdu_valid_o,
    output logic                mdu_stall_req_o,
    output logic                mdu_busy_o
);

    localparam int CNT_W = $clog2(ITER_NUM);

    mdu_state_t          state_q, state_d;
    logic [MDU_OP_W-1:0] op_q, op_d;
    logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d, busy_q, busy_d;

    logic                a_neg_s, b_neg_s, div_zero_s, div_ovf_s, accept_s, div_start_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_nxt_s, mul_res_s;
    logic [XLEN-1:0]     div_quo_s, div_rem_s, quo_fix_s, rem_fix_s;
    logic                div_last_s;

`ifdef RV_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_a_s, fast_b_s, fast_prod_s;
    assign fast_a_s    = {{XLEN{a_neg_s}}, mdu_port_a_i};
    assign fast_b_s    = {{XLEN{b_neg_s}}, mdu_port_b_i};
    assign fast_prod_s = fast_a_s * fast_b_s;
`endif

    // Operand magnitudes, special divide cases and the per-step datapaths.
    always_comb begin
        a_neg_s    = mdu_signed_a(mdu_op_i) && mdu_port_a_i[XLEN-1];
        b_neg_s    = mdu_signed_b(mdu_op_i) && mdu_port_b_i[XLEN-1];
        a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - mdu_port_a_i) : mdu_port_a_i;
        b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - mdu_port_b_i) : mdu_port_b_i;
        div_zero_s = (mdu_port_b_i == {XLEN{1'b0}});
        div_ovf_s  = ((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM))
                     && (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (mdu_port_b_i == {XLEN{1'b1}});
        accept_s   = (state_q == IDLE) && mdu_req_i && !mdu_kill_i;
        div_start_s = accept_s && !mdu_is_mul(mdu_op_i) && !div_zero_s && !div_ovf_s;

        mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_nxt_s  = {mul_sum_s, prod_q[XLEN-1:1]};
        mul_res_s  = neg_res_q ? ({(2*XLEN){1'b0}} - mul_nxt_s) : mul_nxt_s;
        quo_fix_s  = neg_res_q ? ({XLEN{1'b0}} - div_quo_s) : div_quo_s;
        rem_fix_s  = neg_rem_q ? ({XLEN{1'b0}} - div_rem_s) : div_rem_s;
    end

    rv_mdu_div_core #(
        .XLEN     (XLEN),
        .ITER_NUM (ITER_NUM)
    ) u_div_core (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (div_start_s),
        .step_i      (state_q == DIV),
        .dividend_i  (a_mag_s),
        .divisor_i   (b_mag_s),
        .quotient_o  (div_quo_s),
        .remainder_o (div_rem_s),
        .last_o      (div_last_s)
    );

    // FSM next-state and result capture; the result only changes on entry to DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d      = mdu_op_i;
                    neg_res_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    mcand_d   = a_mag_s;
                    prod_d    = {{XLEN{1'b0}}, b_mag_s};
                    cnt_d     = {CNT_W{1'b0}};
                    if (mdu_is_mul(mdu_op_i)) begin
`ifdef RV_MDU_FAST_MUL_EN
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = (mdu_op_i == MDU_MUL) ? fast_prod_s[XLEN-1:0]
                                                         : fast_prod_s[2*XLEN-1:XLEN];
`else
                        state_d  = MUL;
`endif
                    end else if (div_zero_s) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = mdu_is_rem(mdu_op_i) ? mdu_port_a_i : MDU_DIV_ZERO_Q;
                    end else if (div_ovf_s) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = mdu_is_rem(mdu_op_i) ? {XLEN{1'b0}} : mdu_port_a_i;
                    end else begin
                        state_d  = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mdu_kill_i) begin
                    state_d = IDLE;
                end else begin
                    prod_d = mul_nxt_s;
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(ITER_NUM - 1)) begin
                        state_d  = DONE;
                        valid_d  = 1'b1;
                        result_d = (op_q == MDU_MUL) ? mul_res_s[XLEN-1:0]
                                                     : mul_res_s[2*XLEN-1:XLEN];
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            DIV: begin
                if (mdu_kill_i) begin
                    state_d = IDLE;
                end else if (div_last_s) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    result_d = mdu_is_rem(op_q) ? rem_fix_s : quo_fix_s;
                end else begin
                    state_d = DIV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset overrides any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            op_q      <= MDU_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= {XLEN{1'b0}};
            prod_q    <= {(2*XLEN){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            result_q  <= {XLEN{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign mdu_result_o    = result_q;
    assign mdu_valid_o     = valid_q;
    assign mdu_busy_o      = busy_q;
    assign mdu_stall_req_o = mdu_req_i && !valid_q && !mdu_kill_i;

endmodule

// File: tb/tb_rv_mdu.sv
// Directed bench for rv_mdu; expected latencies follow RV_MDU_FAST_MUL_EN.
module tb_rv_mdu;
    import rv_mdu_pkg::*;

`ifdef RV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic                clk;
    logic                rst_n;
    logic                req;
    logic [MDU_OP_W-1:0] op;
    logic [31:0]         a, b;
    logic                kill;
    logic [31:0]         result;
    logic                valid, stall, busy;

    int cmp_n = 0;
    int err_n = 0;

    rv_mdu dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .mdu_req_i       (req),
        .mdu_op_i        (op),
        .mdu_port_a_i    (a),
        .mdu_port_b_i    (b),
        .mdu_kill_i      (kill),
        .mdu_result_o    (result),
        .mdu_valid_o     (valid),
        .mdu_stall_req_o (stall),
        .mdu_busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [MDU_OP_W-1:0] o, input logic [31:0] x, input logic [31:0] y);
        req = 1'b1;
        op  = o;
        a   = x;
        b   = y;
    endtask

    // Waits for valid, counting negedges from the issue point; drops req on valid.
    task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat,
                               input bit scramble);
        int  lat;
        bit  stall_ok;
        lat      = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (scramble) begin
                a  = $urandom;
                b  = $urandom;
                op = MDU_OP_W'($urandom_range(7, 0));
            end
            #1;
            if (!valid && (stall !== 1'b1)) stall_ok = 1'b0;
        end while (!valid && lat < 100);
        check({tag, "_result"}, {32'd0, result}, {32'd0, exp});
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_held"}, {63'd0, stall_ok}, 64'd1);
        check({tag, "_stall_at_valid"}, {63'd0, stall}, 64'd0);
        req = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_valid_pulse"}, {62'd0, valid, busy}, 64'd0);
    endtask

    initial begin
        int valid_seen;
        rst_n = 1'b0;
        req   = 1'b0;
        op    = MDU_MUL;
        a     = 32'd0;
        b     = 32'd0;
        kill  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {29'd0, result, valid, busy, stall}, 64'd0);
        rst_n = 1'b1;

        issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_result("mul_7_m3", 32'hFFFF_FFEB, MUL_LAT, 1'b0);
        issue(MDU_MULH, 32'h8000_0000, 32'h8000_0000);
        wait_result("mulh_min", 32'h4000_0000, MUL_LAT, 1'b0);
        issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mulhsu", 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mulhu", 32'hFFFF_FFFE, MUL_LAT, 1'b0);

        issue(MDU_DIV, 32'hFFFF_FFEC, 32'd3);
        wait_result("div_m20_3", 32'hFFFF_FFFA, DIV_LAT, 1'b0);
        issue(MDU_REM, 32'hFFFF_FFEC, 32'd3);
        wait_result("rem_m20_3", 32'hFFFF_FFFE, DIV_LAT, 1'b0);
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_result("divu_100_7", 32'd14, DIV_LAT, 1'b1);
        issue(MDU_REMU, 32'd100, 32'd7);
        wait_result("remu_100_7", 32'd2, DIV_LAT, 1'b0);

        issue(MDU_DIVU, 32'd5, 32'd0);
        wait_result("divu_by0", 32'hFFFF_FFFF, 1, 1'b0);
        issue(MDU_REM, 32'd5, 32'd0);
        wait_result("rem_by0", 32'd5, 1, 1'b0);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 32'h8000_0000, 1, 1'b0);
        issue(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("rem_ovf", 32'd0, 1, 1'b0);

        // Kill while idle blocks acceptance.
        issue(MDU_DIVU, 32'd9, 32'd0);
        kill = 1'b1;
        valid_seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (valid || busy) valid_seen++;
        end
        check("idle_kill_blocks", 64'(valid_seen), 64'd0);
        check("idle_kill_stall", {63'd0, stall}, 64'd0);
        kill = 1'b0;
        req  = 1'b0;

        // Kill a divide at iteration 10.
        issue(MDU_DIV, 32'hFFFF_FFEC, 32'd3);
        repeat (11) @(negedge clk);
        #1;
        check("div_busy_before_kill", {63'd0, busy}, 64'd1);
        kill = 1'b1;
        #1;
        check("kill_stall_low", {63'd0, stall}, 64'd0);
        @(negedge clk);
        #1;
        check("kill_busy_valid", {62'd0, busy, valid}, 64'd0);
        kill = 1'b0;
        req  = 1'b0;
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) valid_seen++;
        end
        check("kill_no_valid", 64'(valid_seen), 64'd0);
        #1;
        check("kill_result_kept", {32'd0, result}, 64'd0);
        issue(MDU_MUL, 32'd3, 32'd4);
        wait_result("mul_3_4", 32'd12, MUL_LAT, 1'b0);

        // Reset in the middle of a multiply, then restart with req held.
        issue(MDU_MUL, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midop_reset", {29'd0, result, valid, busy, 1'b0}, 64'd0);
        rst_n = 1'b1;
        wait_result("mul_after_rst", 32'd30, MUL_LAT, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
